// File: rtl/reg_file.sv
// reg_file: 32-entry architectural register file written by the WB stage.
//   clk, reset        : system clock, synchronous active-high reset
//   wb_reg_write      : WB write enable
//   wb_write_reg      : WB destination register
//   wb_write_data     : WB writeback data
//   rs_addr, rt_addr  : ID-stage read addresses
//   rs_data, rt_data  : combinational read data (write-first bypass when BYPASS=1)
//   dbg_addr/dbg_data : combinational debug read of stored contents, never bypassed
//   wr_count          : number of committed writes since reset (wraps)
//   last_wr_reg/data  : address and data of the most recent committed write
module reg_file #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_reg_write,
   input  logic [ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [31:0]       wr_count,
   output logic [ADDR_W-1:0] last_wr_reg,
   output logic [DATA_W-1:0] last_wr_data
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned CNT_W   = 32;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              commit_c;

   // A write only commits when it targets a non-zero register.
   assign commit_c = wb_reg_write && (wb_write_reg != '0);

   // Storage, activity counter and last-write capture; reset wins over a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
         wr_count     <= '0;
         last_wr_reg  <= '0;
         last_wr_data <= '0;
      end else if (commit_c) begin
         regs[wb_write_reg] <= wb_write_data;
         wr_count           <= wr_count + CNT_W'(1);
         last_wr_reg        <= wb_write_reg;
         last_wr_data       <= wb_write_data;
      end
   end

   // Read port A: r0 is always zero; bypass is ungated by reset so it stays live.
   always_comb begin
      rs_data = '0;
      if (rs_addr != '0) begin
         if ((BYPASS != 0) && commit_c && (wb_write_reg == rs_addr)) begin
            rs_data = wb_write_data;
         end else begin
            rs_data = regs[rs_addr];
         end
      end
   end

   // Read port B: same rule as port A, evaluated independently.
   always_comb begin
      rt_data = '0;
      if (rt_addr != '0) begin
         if ((BYPASS != 0) && commit_c && (wb_write_reg == rt_addr)) begin
            rt_data = wb_write_data;
         end else begin
            rt_data = regs[rt_addr];
         end
      end
   end

   // Debug port shows stored contents only.
   always_comb begin
      dbg_data = '0;
      if (dbg_addr != '0) begin
         dbg_data = regs[dbg_addr];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Two instances share all inputs: dut (BYPASS=1) and dut0 (BYPASS=0).
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  dbg_addr;

   logic [31:0] rs_data, rt_data, dbg_data, wr_count, last_wr_data;
   logic [4:0]  last_wr_reg;
   logic [31:0] rs_data0, rt_data0, dbg_data0, wr_count0, last_wr_data0;
   logic [4:0]  last_wr_reg0;

   int total;
   int bad;

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
      .clk(clk), .reset(reset),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .wr_count(wr_count), .last_wr_reg(last_wr_reg), .last_wr_data(last_wr_data)
   );

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
      .clk(clk), .reset(reset),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data0), .rt_data(rt_data0),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data0),
      .wr_count(wr_count0), .last_wr_reg(last_wr_reg0), .last_wr_data(last_wr_data0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_reg_write  = 1'b0;
      wb_write_reg  = '0;
      wb_write_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rs_addr = 5'd5; rt_addr = 5'd31;
      #1;
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL reset_wr_count got=%h exp=%h", wr_count, 32'd0); end
      total++; if (last_wr_reg !== 5'd0) begin bad++; $display("FAIL reset_last_reg got=%h exp=%h", last_wr_reg, 5'd0); end
      total++; if (last_wr_data !== 32'd0) begin bad++; $display("FAIL reset_last_data got=%h exp=%h", last_wr_data, 32'd0); end
      total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL reset_rs got=%h exp=%h", rs_data, 32'd0); end
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL reset_rt got=%h exp=%h", rt_data, 32'd0); end
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         #1;
         total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL reset_dbg[%0d] got=%h exp=%h", a, dbg_data, 32'd0); end
      end
   endtask

   task automatic test_basic_write();
      wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hDEADBEEF;
      rs_addr = 5'd1; rt_addr = 5'd2;
      tick();
      idle_inputs();
      rs_addr = 5'd5;
      #1;
      total++; if (rs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rs got=%h exp=%h", rs_data, 32'hDEADBEEF); end
      total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL basic_wr_count got=%h exp=%h", wr_count, 32'd1); end
      total++; if (last_wr_reg !== 5'd5) begin bad++; $display("FAIL basic_last_reg got=%h exp=%h", last_wr_reg, 5'd5); end
      total++; if (last_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_last_data got=%h exp=%h", last_wr_data, 32'hDEADBEEF); end
   endtask

   task automatic test_r0_write();
      wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'h12345678;
      rs_addr = 5'd0; rt_addr = 5'd0;
      #1;
      total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL r0_same_rs got=%h exp=%h", rs_data, 32'd0); end
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL r0_same_rt got=%h exp=%h", rt_data, 32'd0); end
      tick();
      idle_inputs();
      #1;
      total++; if (rs_data !== 32'd0) begin bad++; $display("FAIL r0_next_rs got=%h exp=%h", rs_data, 32'd0); end
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL r0_next_rt got=%h exp=%h", rt_data, 32'd0); end
      total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL r0_wr_count got=%h exp=%h", wr_count, 32'd1); end
      total++; if (last_wr_reg !== 5'd5) begin bad++; $display("FAIL r0_last_reg got=%h exp=%h", last_wr_reg, 5'd5); end
   endtask

   task automatic test_bypass();
      wb_reg_write = 1'b1; wb_write_reg = 5'd7; wb_write_data = 32'h11111111;
      tick();
      wb_reg_write = 1'b1; wb_write_reg = 5'd7; wb_write_data = 32'h22222222;
      rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
      #1;
      total++; if (rs_data !== 32'h22222222) begin bad++; $display("FAIL byp_rs got=%h exp=%h", rs_data, 32'h22222222); end
      total++; if (rt_data !== 32'h22222222) begin bad++; $display("FAIL byp_rt got=%h exp=%h", rt_data, 32'h22222222); end
      total++; if (dbg_data !== 32'h11111111) begin bad++; $display("FAIL byp_dbg_same got=%h exp=%h", dbg_data, 32'h11111111); end
      total++; if (rs_data0 !== 32'h11111111) begin bad++; $display("FAIL nobyp_rs got=%h exp=%h", rs_data0, 32'h11111111); end
      total++; if (rt_data0 !== 32'h11111111) begin bad++; $display("FAIL nobyp_rt got=%h exp=%h", rt_data0, 32'h11111111); end
      rt_addr = 5'd6;
      #1;
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL byp_other_addr got=%h exp=%h", rt_data, 32'd0); end
      wb_reg_write = 1'b0;
      #1;
      total++; if (rs_data !== 32'h11111111) begin bad++; $display("FAIL byp_disabled got=%h exp=%h", rs_data, 32'h11111111); end
      wb_reg_write = 1'b1;
      tick();
      idle_inputs();
      #1;
      total++; if (dbg_data !== 32'h22222222) begin bad++; $display("FAIL byp_dbg_after got=%h exp=%h", dbg_data, 32'h22222222); end
      total++; if (rs_data0 !== 32'h22222222) begin bad++; $display("FAIL nobyp_after got=%h exp=%h", rs_data0, 32'h22222222); end
      total++; if (wr_count !== 32'd3) begin bad++; $display("FAIL byp_wr_count got=%h exp=%h", wr_count, 32'd3); end
   endtask

   task automatic test_fill_sweep();
      logic [31:0] exp;
      do_reset();
      for (int i = 1; i < 32; i++) begin
         wb_reg_write = 1'b1; wb_write_reg = 5'(i); wb_write_data = 32'(i) * 32'h01010101;
         tick();
      end
      idle_inputs();
      for (int a = 0; a < 32; a++) begin
         dbg_addr = 5'(a);
         exp = 32'(a) * 32'h01010101;
         #1;
         total++; if (dbg_data !== exp) begin bad++; $display("FAIL fill_dbg[%0d] got=%h exp=%h", a, dbg_data, exp); end
         total++; if (dbg_data0 !== exp) begin bad++; $display("FAIL fill_dbg0[%0d] got=%h exp=%h", a, dbg_data0, exp); end
      end
      total++; if (wr_count !== 32'd31) begin bad++; $display("FAIL fill_wr_count got=%h exp=%h", wr_count, 32'd31); end
      total++; if (last_wr_reg !== 5'd31) begin bad++; $display("FAIL fill_last_reg got=%h exp=%h", last_wr_reg, 5'd31); end
      total++; if (last_wr_data !== 32'h1F1F1F1F) begin bad++; $display("FAIL fill_last_data got=%h exp=%h", last_wr_data, 32'h1F1F1F1F); end
   endtask

   task automatic test_reset_priority();
      reset = 1'b1;
      wb_reg_write = 1'b1; wb_write_reg = 5'd9; wb_write_data = 32'hAAAA5555;
      rs_addr = 5'd9; rt_addr = 5'd31; dbg_addr = 5'd9;
      #1;
      total++; if (rs_data !== 32'hAAAA5555) begin bad++; $display("FAIL rstpri_bypass got=%h exp=%h", rs_data, 32'hAAAA5555); end
      tick();
      reset = 1'b0;
      idle_inputs();
      #1;
      total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL rstpri_r9 got=%h exp=%h", dbg_data, 32'd0); end
      total++; if (rt_data !== 32'd0) begin bad++; $display("FAIL rstpri_r31 got=%h exp=%h", rt_data, 32'd0); end
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL rstpri_wr_count got=%h exp=%h", wr_count, 32'd0); end
      total++; if (last_wr_data !== 32'd0) begin bad++; $display("FAIL rstpri_last_data got=%h exp=%h", last_wr_data, 32'd0); end
      total++; if (last_wr_reg !== 5'd0) begin bad++; $display("FAIL rstpri_last_reg got=%h exp=%h", last_wr_reg, 5'd0); end
      wb_reg_write = 1'b1; wb_write_reg = 5'd9; wb_write_data = 32'h5;
      tick();
      idle_inputs();
      #1;
      total++; if (dbg_data !== 32'h5) begin bad++; $display("FAIL rstpri_resume got=%h exp=%h", dbg_data, 32'h5); end
      total++; if (wr_count !== 32'd1) begin bad++; $display("FAIL rstpri_resume_cnt got=%h exp=%h", wr_count, 32'd1); end
   endtask

   task automatic test_wrap();
      force dut.wr_count = 32'hFFFFFFFF;
      #1;
      release dut.wr_count;
      #1;
      total++; if (wr_count !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=%h", wr_count, 32'hFFFFFFFF); end
      wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'h33;
      tick();
      idle_inputs();
      #1;
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL wrap_count got=%h exp=%h", wr_count, 32'd0); end
      total++; if (last_wr_reg !== 5'd3) begin bad++; $display("FAIL wrap_last_reg got=%h exp=%h", last_wr_reg, 5'd3); end
      tick();
      #1;
      total++; if (wr_count !== 32'd0) begin bad++; $display("FAIL wrap_hold got=%h exp=%h", wr_count, 32'd0); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      idle_inputs();
      rs_addr  = '0;
      rt_addr  = '0;
      dbg_addr = '0;
      test_reset();
      test_basic_write();
      test_r0_write();
      test_bypass();
      test_fill_sweep();
      test_reset_priority();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Architectural 32-entry general-purpose register file; the receiving end of the writeback interface driven by the WB stage (wb_reg_write / wb_write_reg / wb_write_data).
- Supplies two combinational read ports (rs, rt) to the ID stage.
- Write-first bypass, so an ID-stage read in the same cycle as a WB write sees the new value.
- Debug read port and write-activity counters for bench and board-level observation.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the stored value only

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wb_reg_write  input  1  write enable from the WB stage
wb_write_reg  input  ADDR_W  destination register from the WB stage
wb_write_data  input  DATA_W  writeback data from the WB stage
rs_addr  input  ADDR_W  ID-stage read address A
rt_addr  input  ADDR_W  ID-stage read address B
rs_data  output  DATA_W  read data A (combinational)
rt_data  output  DATA_W  read data B (combinational)
dbg_addr  input  ADDR_W  debug read address
dbg_data  output  DATA_W  debug read data (combinational, stored value only, no bypass)
wr_count  output  32  count of committed writes since reset
last_wr_reg  output  ADDR_W  address of most recent committed write
last_wr_data  output  DATA_W  data of most recent committed write

Behaviour:
- Committed write: wb_reg_write=1 and wb_write_reg!=0 at a rising clk edge with reset=0. The entry is updated at that edge and is visible in storage from the next cycle.
- Register 0 is hardwired to zero:
  - A write to address 0 is discarded and is not counted.
  - A read of address 0 on any port returns 0, including when a same-cycle write targets 0.
- Read ports, BYPASS=1: if wb_reg_write=1, wb_write_reg!=0 and wb_write_reg==rs_addr, then rs_data=wb_write_data; otherwise rs_data is the stored entry. rt_data follows the identical rule independently.
- Read ports, BYPASS=0: reads return the stored entry only. A same-cycle write is visible one cycle later.
- Both read ports may address the same register and the same bypass target simultaneously; both return identical data.
- Reads are purely combinational, with zero-cycle latency from address to data.
- wr_count:
  - Increments by 1 on each committed write.
  - Wraps from 0xFFFFFFFF to 0.
  - Not incremented when reset is asserted.
- last_wr_reg / last_wr_data: loaded on each committed write; hold their value otherwise.
- Reset (synchronous, active-high):
  - At a rising edge with reset=1, all 32 entries clear to 0, wr_count=0, last_wr_reg=0, last_wr_data=0.
  - Reset takes priority over a simultaneous write; that write is lost and not counted.
  - Reset asserted mid-stream clears state on that edge; normal writes resume on the first edge with reset=0.
- Bypass is active during reset for read outputs (combinational path). Stored state is still cleared.
- Output values after reset: rs_data, rt_data and dbg_data read 0 for all addresses, absent a bypass hit.
- No X propagation: every storage element has a defined reset value.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5; next cycle rs_addr=5 -> rs_data=0xDEADBEEF, wr_count=1, last_wr_reg=5, last_wr_data=0xDEADBEEF.
2. Write 0x12345678 to r0; rs_addr=rt_addr=0 in the same and the next cycle -> both read 0, wr_count unchanged.
3. BYPASS=1: r7 holds 0x11111111; in one cycle write 0x22222222 to r7 with rs_addr=7, rt_addr=7 -> both outputs 0x22222222 in that cycle; dbg_addr=7 shows 0x11111111 in that cycle and 0x22222222 after the edge. With BYPASS=0, rs_data=0x11111111 in that cycle.
4. Write r1..r31 with value = index*0x01010101 on consecutive cycles, then sweep dbg_addr 0..31 -> dbg_data matches, r0=0, wr_count=31, last_wr_reg=31.
5. Write 0xAAAA5555 to r9 in the same cycle reset=1 -> after the edge r9=0, wr_count=0, last_wr_data=0; next cycle write r9=0x5 -> r9=0x5, wr_count=1.
6. Force wr_count to 0xFFFFFFFF (via 2^32-1 writes or a bench preload), then one committed write -> wr_count=0.
